fpga_clkgen_multi: RTL and testbench

Parametrised, multi-channel integer clock generator for the FPGA clock tree. It derives NUM_CH divided clocks and matching clock-enable strobes from a single oscillator. Each channel's divisor can be reprogrammed at run time without glitches, and each channel reports its own lock status. It sits between the board oscillator input and the peripheral clock consumers, where a fixed-ratio PLL path is not available or not wanted.

---
 rtl/fpga_clkgen_multi.sv | 141 ++++++++++++++
 tb/tb_fpga_clkgen_multi.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_clkgen_multi.sv
// Multi-channel integer clock divider: per-channel divided clock, rising-edge strobe and lock flag,
// with divisor updates taking effect only at a period boundary.
module fpga_clkgen_multi #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned LOCK_CYCLES = 256,
    parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT = {NUM_CH{DIV_W'(2)}},
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              osc,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_req,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_ack,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] clk_stb,
    output logic [NUM_CH-1:0] pll_locked
);

    localparam int unsigned LCW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} ch_state_e;

    ch_state_e         state_q  [NUM_CH];
    ch_state_e         state_d  [NUM_CH];
    logic [DIV_W-1:0]  div_q    [NUM_CH];
    logic [DIV_W-1:0]  div_d    [NUM_CH];
    logic [DIV_W-1:0]  pend_q   [NUM_CH];
    logic [DIV_W-1:0]  pend_d   [NUM_CH];
    logic [DIV_W-1:0]  phase_q  [NUM_CH];
    logic [DIV_W-1:0]  phase_d  [NUM_CH];
    logic [LCW-1:0]    lock_q   [NUM_CH];
    logic [LCW-1:0]    lock_d   [NUM_CH];
    logic [NUM_CH-1:0] pend_vld_q;
    logic [NUM_CH-1:0] pend_vld_d;
    logic [NUM_CH-1:0] clk_out_d;
    logic [NUM_CH-1:0] clk_stb_d;
    logic [NUM_CH-1:0] locked_d;
    logic              cfg_ack_d;
    logic              accept_c;

    assign accept_c = cfg_req && !cfg_ack;

    // Per-channel next state: period boundaries apply pending divisors and decide run/stop
    always_comb begin
        logic [DIV_W-1:0] d_eff;
        logic [DIV_W-1:0] h_act;
        logic [DIV_W-1:0] ph_inc;
        logic             boundary;
        logic             restart;
        cfg_ack_d = accept_c;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]    = state_q[i];
            div_d[i]      = div_q[i];
            pend_d[i]     = pend_q[i];
            pend_vld_d[i] = pend_vld_q[i];
            phase_d[i]    = phase_q[i];
            lock_d[i]     = lock_q[i];
            clk_out_d[i]  = clk_out[i];
            clk_stb_d[i]  = 1'b0;
            locked_d[i]   = pll_locked[i];

            d_eff    = pend_vld_q[i] ? pend_q[i] : div_q[i];
            h_act    = div_q[i] - (div_q[i] >> 1);
            ph_inc   = phase_q[i] + DIV_W'(1);
            boundary = (state_q[i] == ST_STOP) || (phase_q[i] == div_q[i] - DIV_W'(1));
            restart  = 1'b0;

            if (boundary) begin
                if (pend_vld_q[i]) begin
                    div_d[i]      = pend_q[i];
                    pend_vld_d[i] = 1'b0;
                end
                phase_d[i] = '0;
                if (ch_en[i] && (d_eff != '0)) begin
                    state_d[i]   = ST_RUN;
                    clk_out_d[i] = 1'b1;
                    clk_stb_d[i] = 1'b1;
                    restart      = (state_q[i] == ST_STOP) || pend_vld_q[i];
                end else begin
                    state_d[i]   = ST_STOP;
                    clk_out_d[i] = 1'b0;
                end
            end else begin
                phase_d[i]   = ph_inc;
                clk_out_d[i] = (ph_inc < h_act);
            end

            if ((state_d[i] == ST_STOP) || restart) begin
                lock_d[i]   = '0;
                locked_d[i] = 1'b0;
            end else begin
                if (lock_q[i] != LCW'(LOCK_CYCLES)) begin
                    lock_d[i] = lock_q[i] + LCW'(1);
                end
                locked_d[i] = (lock_d[i] == LCW'(LOCK_CYCLES));
            end

            // An accepted request overrides lock progress and becomes the pending divisor
            if (accept_c && (cfg_ch == CH_W'(i))) begin
                pend_d[i]     = cfg_div;
                pend_vld_d[i] = 1'b1;
                lock_d[i]     = '0;
                locked_d[i]   = 1'b0;
            end
        end
    end

    always_ff @(posedge osc or negedge reset_n) begin
        if (!reset_n) begin
            cfg_ack    <= 1'b0;
            clk_out    <= '0;
            clk_stb    <= '0;
            pll_locked <= '0;
            pend_vld_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_STOP;
                div_q[i]   <= DIV_INIT[i*DIV_W +: DIV_W];
                pend_q[i]  <= '0;
                phase_q[i] <= '0;
                lock_q[i]  <= '0;
            end
        end else begin
            cfg_ack    <= cfg_ack_d;
            clk_out    <= clk_out_d;
            clk_stb    <= clk_stb_d;
            pll_locked <= locked_d;
            pend_vld_q <= pend_vld_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                div_q[i]   <= div_d[i];
                pend_q[i]  <= pend_d[i];
                phase_q[i] <= phase_d[i];
                lock_q[i]  <= lock_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fpga_clkgen_multi.sv
// Directed bench for fpga_clkgen_multi; five channels so that cfg_ch = NUM_CH is encodable.
module tb_fpga_clkgen_multi;

    localparam int unsigned NUM_CH = 5;
    localparam int unsigned DIV_W  = 8;
    localparam int unsigned CH_W   = 3;

    logic              osc = 1'b0;
    logic              reset_n;
    logic [NUM_CH-1:0] ch_en;
    logic              cfg_req;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_ack;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] clk_stb;
    logic [NUM_CH-1:0] pll_locked;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   n     = 0;

    fpga_clkgen_multi #(
        .NUM_CH     (NUM_CH),
        .DIV_W      (DIV_W),
        .LOCK_CYCLES(256),
        .DIV_INIT   ({NUM_CH{8'd2}})
    ) dut (
        .osc       (osc),
        .reset_n   (reset_n),
        .ch_en     (ch_en),
        .cfg_req   (cfg_req),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ack   (cfg_ack),
        .clk_out   (clk_out),
        .clk_stb   (clk_stb),
        .pll_locked(pll_locked)
    );

    always #5 osc = ~osc;

    task automatic tick();
        @(posedge osc);
        #1;
        n++;
    endtask

    task automatic wait_to(input int target);
        while (n < target) tick();
    endtask

    task automatic push_exp(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [7:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL sb_empty observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL %s n=%0d observed=%0h expected=%0h", e.tag, n, obs, e.exp);
            end
        end
    endtask

    // Issue one request; the accept edge is the next tick and the ack is checked there
    task automatic req(input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] dv);
        cfg_ch  = ch;
        cfg_div = dv;
        cfg_req = 1'b1;
        push_exp("cfg_ack", 8'h01);
        tick();
        check(8'(cfg_ack));
        cfg_req = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        ch_en   = '1;
        cfg_req = 1'b0;
        cfg_ch  = '0;
        cfg_div = '0;
        tick();
        tick();
        push_exp("rst_out", 8'h00); check(8'(clk_out));
        push_exp("rst_stb", 8'h00); check(8'(clk_stb));
        push_exp("rst_lock", 8'h00); check(8'(pll_locked));
        push_exp("rst_ack", 8'h00); check(8'(cfg_ack));

        // Reset release: all channels divide by 2
        reset_n = 1'b1;
        n = 0;
        push_exp("e1_out", 8'h1f); push_exp("e1_stb", 8'h1f);
        tick(); check(8'(clk_out)); check(8'(clk_stb));
        push_exp("e2_out", 8'h00); push_exp("e2_stb", 8'h00);
        tick(); check(8'(clk_out)); check(8'(clk_stb));
        push_exp("e3_out", 8'h1f);
        tick(); check(8'(clk_out));
        wait_to(256);
        push_exp("lock_early", 8'h00); check(8'(pll_locked));
        push_exp("lock_all", 8'h1f);
        tick(); check(8'(pll_locked));

        // Ch1 -> 5: current period completes, then 3 high / 2 low
        req(3'd1, 8'd5);
        push_exp("ch1_unlock", 8'h1d); check(8'(pll_locked));
        push_exp("e258_out", 8'h00); check(8'(clk_out));
        push_exp("ack_pulse", 8'h00); push_exp("e259_out", 8'h1f); push_exp("e259_stb", 8'h1f);
        tick(); check(8'(cfg_ack)); check(8'(clk_out)); check(8'(clk_stb));
        push_exp("e260_out", 8'h02);
        tick(); check(8'(clk_out));
        push_exp("e261_out", 8'h1f);
        tick(); check(8'(clk_out));
        push_exp("e262_out", 8'h00);
        tick(); check(8'(clk_out));
        push_exp("e263_out", 8'h1d); push_exp("e263_stb", 8'h1d);
        tick(); check(8'(clk_out)); check(8'(clk_stb));
        push_exp("e264_out", 8'h02); push_exp("e264_stb", 8'h02);
        tick(); check(8'(clk_out)); check(8'(clk_stb));
        wait_to(514);
        push_exp("ch1_lock_early", 8'h00); check(8'(pll_locked & 5'h02));
        push_exp("ch1_relock", 8'h1f);
        tick(); check(8'(pll_locked));

        // Ch2 -> 0 (stopped), then -> 1 (held high)
        req(3'd2, 8'd0);
        push_exp("ch2_unlock", 8'h1b); check(8'(pll_locked));
        push_exp("ch2_stop_a", 8'h00);
        tick(); check(8'(clk_out & 5'h04));
        push_exp("ch2_stop_b", 8'h00);
        tick(); check(8'(clk_out & 5'h04));
        wait_to(520);
        push_exp("ch2_d0_out", 8'h00); check(8'(clk_out & 5'h04));
        push_exp("ch2_d0_lock", 8'h00); check(8'(pll_locked & 5'h04));
        req(3'd2, 8'd1);
        push_exp("ch2_d1_out_a", 8'h04); push_exp("ch2_d1_stb_a", 8'h04);
        tick(); check(8'(clk_out & 5'h04)); check(8'(clk_stb & 5'h04));
        push_exp("ch2_d1_out_b", 8'h04); push_exp("ch2_d1_stb_b", 8'h04);
        tick(); check(8'(clk_out & 5'h04)); check(8'(clk_stb & 5'h04));
        wait_to(777);
        push_exp("ch2_lock_early", 8'h00); check(8'(pll_locked & 5'h04));
        push_exp("ch2_lock", 8'h04);
        tick(); check(8'(pll_locked & 5'h04));

        // Ch0 -> 4, then disable during the high phase
        req(3'd0, 8'd4);
        tick();
        push_exp("ch0_d4_out", 8'h01); push_exp("ch0_d4_stb", 8'h01);
        tick(); check(8'(clk_out & 5'h01)); check(8'(clk_stb & 5'h01));
        ch_en[0] = 1'b0;
        push_exp("ch0_finish_hi", 8'h01);
        tick(); check(8'(clk_out & 5'h01));
        push_exp("ch0_finish_lo", 8'h00);
        tick(); check(8'(clk_out & 5'h01));
        tick();
        push_exp("ch0_stop_out", 8'h00); push_exp("ch0_stop_stb", 8'h00); push_exp("ch0_stop_lock", 8'h00);
        tick(); check(8'(clk_out & 5'h01)); check(8'(clk_stb & 5'h01)); check(8'(pll_locked & 5'h01));
        wait_to(788);
        push_exp("ch0_held", 8'h00); check(8'(clk_out & 5'h01));
        ch_en[0] = 1'b1;
        push_exp("ch0_reen_out", 8'h01); push_exp("ch0_reen_stb", 8'h01);
        tick(); check(8'(clk_out & 5'h01)); check(8'(clk_stb & 5'h01));
        push_exp("ch0_reen_hi", 8'h01); push_exp("ch0_reen_nostb", 8'h00);
        tick(); check(8'(clk_out & 5'h01)); check(8'(clk_stb & 5'h01));
        push_exp("ch0_reen_lo", 8'h00);
        tick(); check(8'(clk_out & 5'h01));

        // Ch3 -> 5, then 6 and 3 before the wrap: only 3 applies
        req(3'd3, 8'd5);
        push_exp("ch3_d5_stb", 8'h08);
        tick(); check(8'(clk_stb & 5'h08));
        wait_to(798);
        push_exp("ch3_wrap_stb", 8'h08); check(8'(clk_stb & 5'h08));
        req(3'd3, 8'd6);
        tick();
        req(3'd3, 8'd3);
        push_exp("ch3_old_lo", 8'h00);
        tick(); check(8'(clk_out & 5'h08));
        push_exp("ch3_apply_stb", 8'h08);
        tick(); check(8'(clk_stb & 5'h08));
        req(3'd5, 8'd7);
        push_exp("bad_ch_lock", 8'h16); check(8'(pll_locked));
        push_exp("e805_out", 8'h17);
        tick(); check(8'(clk_out));
        push_exp("e806_out", 8'h0f); push_exp("e806_stb", 8'h0c);
        tick(); check(8'(clk_out)); check(8'(clk_stb));

        // Pending update on ch4, then asynchronous reset pulse
        req(3'd4, 8'd7);
        reset_n = 1'b0;
        #2;
        push_exp("arst_out", 8'h00); check(8'(clk_out));
        push_exp("arst_stb", 8'h00); check(8'(clk_stb));
        push_exp("arst_lock", 8'h00); check(8'(pll_locked));
        push_exp("arst_ack", 8'h00); check(8'(cfg_ack));
        reset_n = 1'b1;
        push_exp("post_rst_out1", 8'h1f); push_exp("post_rst_stb1", 8'h1f);
        tick(); check(8'(clk_out)); check(8'(clk_stb));
        push_exp("post_rst_out2", 8'h00);
        tick(); check(8'(clk_out));
        push_exp("post_rst_out3", 8'h1f); push_exp("post_rst_lock", 8'h00);
        tick(); check(8'(clk_out)); check(8'(pll_locked));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
